vga_tile_display: RTL
=====================

// Module: vga_tile_display
// PURPOSE
//  Parametrised VGA tile display: generates 640x480@60 sync timing from the system clock through an
//  internal pixel-enable divider and renders a GRID_W x GRID_H tile map, RGB332 per cell.
//  Holds its own writable tile memory (write port for CPU/top level) with optional tear-free double
//  buffering committed in vertical blanking. Replaces the fixed 1-bit video_memory bus at top level.
// PARAMETERS
//  CLK_DIV    2    system clocks per pixel (pix_en period); >=1
//  GRID_W     10   tiles per row; H_ACTIVE % GRID_W == 0
//  GRID_H     10   tile rows; V_ACTIVE % GRID_H == 0
//  DOUBLE_BUF 0    0: writes visible immediately; 1: writes to back buffer, shown after commit
//  SYNC_POL   0    asserted level of hsync/vsync (0 = active-low)
//  H_ACTIVE/H_FP/H_SYNC/H_BP  640/16/96/48   horizontal timing in pixels (total 800)
//  V_ACTIVE/V_FP/V_SYNC/V_BP  480/10/2/33    vertical timing in lines (total 525)
// PORTS
//  clk          in   1   system clock (50 MHz)
//  rst_n        in   1   asynchronous active-low reset
//  wr_en        in   1   tile write strobe, one write per clk
//  wr_addr      in   AW  tile index row*GRID_W+col, AW=$clog2(GRID_W*GRID_H)
//  wr_data      in   8   RGB332 {r[2:0],g[2:0],b[1:0]}
//  commit       in   1   pulse: request back->front copy (DOUBLE_BUF=1 only)
//  commit_busy  out  1   commit pending, not yet applied
//  frame_start  out  1   one-clk pulse at pix_en where h=0,v=0
//  hsync        out  1   horizontal sync, polarity SYNC_POL
//  vsync        out  1   vertical sync, polarity SYNC_POL
//  vga_r        out  3   red;   vga_g out 3 green;   vga_b out 2 blue
// BEHAVIOUR
//  Reset: div/h/v counters 0, hsync=vsync=~SYNC_POL, rgb=0, commit_busy=0, frame_start=0,
//   all tile memory 0 (front and back). Reset mid-frame restarts at h=0,v=0 on first clk after release.
//  pix_en: asserts one clk in every CLK_DIV (first at div count 0 after reset); all counters/pipeline advance only on pix_en.
//  h_cnt 0..799 wraps; v_cnt increments at h wrap, 0..524 wraps. Active when h<H_ACTIVE && v<V_ACTIVE.
//  Sync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), v in [V_ACTIVE+V_FP, +V_SYNC).
//  Tile index from incremental col/row counters with sub-counters (CELL_W=H_ACTIVE/GRID_W,
//   CELL_H=V_ACTIVE/GRID_H); no dividers/multipliers in the pixel path.
//  Pipeline: S0 counters -> S1 front-memory read + active/sync flags -> S2 output regs.
//   rgb/hsync/vsync lag counter state by exactly 2 pix_en; sync and colour stay aligned.
//   Outside active area rgb=0.
//  Writes: wr_addr >= GRID_W*GRID_H ignored. DOUBLE_BUF=0: write to front, visible from next read.
//   DOUBLE_BUF=1: write to back only.
//  Commit (DOUBLE_BUF=1): commit sets commit_busy; repeated commit while busy has no extra effect.
//   At the pix_en where h=0 and v=V_ACTIVE, whole back copied to front in one clk, commit_busy
//   clears next clk. Write in the copy clk: copy takes pre-write back data, write lands in back.
//   commit arriving in the copy clk is kept pending for next frame.
//  DOUBLE_BUF=0: commit ignored, commit_busy tied 0.
// TESTING
//  Reset: rst_n=0 mid-line -> hsync=vsync=1, rgb=0; release -> first hsync low at clk (656+2)*2, width 192 clks.
//  Timing: hsync period 1600 clks, vsync period 840000 clks, vsync low 3200 clks; frame_start each 840000.
//  DOUBLE_BUF=0, write addr 50=8'hFF -> x 0..63, y 240..287 white; all other pixels 0.
//  DOUBLE_BUF=1, write addr 0=8'hE0, no commit -> tile 0 stays black; commit -> red from the next frame.
//  wr_addr=100 with GRID 10x10 -> no tile changes; commit during copy clk -> busy stays 1, applied next frame.
//  CLK_DIV=1, GRID 8x4 -> cell 80x120 px, hsync period 800 clks, write addr 31 fills x 560..639,y 360..479.

Source files
------------

// File: rtl/vga_tile_display.sv
// -----------------------------------------------------------------------------
// vga_tile_display
//   This module generates VGA sync timing and draws a coloured tile map.
//   The default timing is 640x480 at 60 Hz. The pixel clock comes from the
//   system clock through a pixel-enable divider. The screen is split into a
//   GRID_W x GRID_H grid of cells, and each cell shows one RGB332 value from
//   the internal tile memory.
//
//   Ports
//     clk, rst_n          system clock and asynchronous active-low reset
//     wr_en/addr/data     tile write port, one write per clk.
//                         Writes to an address >= GRID_W*GRID_H are dropped.
//     commit              DOUBLE_BUF=1: request a back->front copy
//     commit_busy         a commit is pending and has not been applied yet
//     frame_start         one-clk pulse at the pixel where h=0,v=0
//     hsync, vsync        sync outputs; the asserted level is SYNC_POL
//     vga_r/g/b           colour {3,3,2} bits; 0 outside the active area
//
//   Commit handshake: a one-clk commit pulse is accepted at any time. It
//   raises commit_busy. The copy happens at the first pixel of vertical
//   blanking (h=0, v=V_ACTIVE). commit_busy drops on the clk after the copy,
//   unless another commit arrived during the copy clk. A commit that arrives
//   while commit_busy is already high is absorbed.
// -----------------------------------------------------------------------------
module vga_tile_display #(
    parameter int CLK_DIV    = 2,
    parameter int GRID_W     = 10,
    parameter int GRID_H     = 10,
    parameter int DOUBLE_BUF = 0,
    parameter bit SYNC_POL   = 1'b0,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    localparam int N_TILES   = GRID_W * GRID_H,
    localparam int AW        = (N_TILES > 1) ? $clog2(N_TILES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          commit,
    output logic          commit_busy,
    output logic          frame_start,
    output logic          hsync,
    output logic          vsync,
    output logic [2:0]    vga_r,
    output logic [2:0]    vga_g,
    output logic [1:0]    vga_b
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int CELL_W   = H_ACTIVE / GRID_W;
    localparam int CELL_H   = V_ACTIVE / GRID_H;
    localparam int HW       = $clog2(H_TOTAL);
    localparam int VW       = $clog2(V_TOTAL);
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CXW      = (CELL_W > 1) ? $clog2(CELL_W) : 1;
    localparam int CYW      = (CELL_H > 1) ? $clog2(CELL_H) : 1;
    localparam int COLW     = (GRID_W > 1) ? $clog2(GRID_W) : 1;
    localparam int ROWW     = (GRID_H > 1) ? $clog2(GRID_H) : 1;

    // ---------------- S0: divider, beam counters, cell counters --------------
    logic [DW-1:0]   div_q, div_d;
    logic [HW-1:0]   h_q, h_d;
    logic [VW-1:0]   v_q, v_d;
    logic [CXW-1:0]  cx_q, cx_d;
    logic [CYW-1:0]  cy_q, cy_d;
    logic [COLW-1:0] col_q, col_d;
    logic [ROWW-1:0] row_q, row_d;
    logic [AW-1:0]   base_q, base_d;    // row_q * GRID_W, kept incrementally
    logic            pix_en;
    logic [AW-1:0]   tile_idx;

    assign pix_en   = (div_q == '0);
    assign tile_idx = base_q + AW'(col_q);

    always_comb begin
        div_d  = (div_q == DW'(CLK_DIV - 1)) ? '0 : div_q + DW'(1);
        h_d    = h_q;
        v_d    = v_q;
        cx_d   = cx_q;
        cy_d   = cy_q;
        col_d  = col_q;
        row_d  = row_q;
        base_d = base_q;
        if (pix_en) begin
            if (h_q == HW'(H_TOTAL - 1)) begin
                h_d   = '0;
                cx_d  = '0;
                col_d = '0;
                if (v_q == VW'(V_TOTAL - 1)) begin
                    v_d    = '0;
                    cy_d   = '0;
                    row_d  = '0;
                    base_d = '0;
                end else begin
                    v_d = v_q + VW'(1);
                    // The row counters wrap to 0 on the last active line, so
                    // they already sit at row 0 through vertical blanking.
                    if (v_q < VW'(V_ACTIVE)) begin
                        if (cy_q == CYW'(CELL_H - 1)) begin
                            cy_d = '0;
                            if (row_q == ROWW'(GRID_H - 1)) begin
                                row_d  = '0;
                                base_d = '0;
                            end else begin
                                row_d  = row_q + ROWW'(1);
                                base_d = base_q + AW'(GRID_W);
                            end
                        end else begin
                            cy_d = cy_q + CYW'(1);
                        end
                    end
                end
            end else begin
                h_d = h_q + HW'(1);
                // The column counters wrap on the last active pixel, so they
                // hold at column 0 through horizontal blanking.
                if (h_q < HW'(H_ACTIVE)) begin
                    if (cx_q == CXW'(CELL_W - 1)) begin
                        cx_d  = '0;
                        col_d = (col_q == COLW'(GRID_W - 1)) ? '0 : col_q + COLW'(1);
                    end else begin
                        cx_d = cx_q + CXW'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            h_q    <= '0;
            v_q    <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            col_q  <= '0;
            row_q  <= '0;
            base_q <= '0;
        end else begin
            div_q  <= div_d;
            h_q    <= h_d;
            v_q    <= v_d;
            cx_q   <= cx_d;
            cy_q   <= cy_d;
            col_q  <= col_d;
            row_q  <= row_d;
            base_q <= base_d;
        end
    end

    // ---------------- tile memory ------------------------------------------
    logic [7:0] front_q [N_TILES];
    logic       wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW + 1)'(N_TILES));

    if (DOUBLE_BUF == 0) begin : g_single
        logic unused_commit;
        assign unused_commit = commit;
        assign commit_busy   = 1'b0;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N_TILES; i++) front_q[i] <= '0;
            end else if (wr_ok) begin
                front_q[wr_addr] <= wr_data;
            end
        end
    end else begin : g_double
        typedef enum logic {CM_IDLE = 1'b0, CM_PENDING = 1'b1} cm_state_e;
        cm_state_e  state_q, state_d;
        logic       copy;
        logic [7:0] back_q [N_TILES];

        assign copy = pix_en && (h_q == '0) && (v_q == VW'(V_ACTIVE)) &&
                      (state_q == CM_PENDING);

        always_comb begin
            state_d = state_q;
            case (state_q)
                CM_IDLE:    if (commit) state_d = CM_PENDING;
                // A commit that arrives during the copy clk stays pending
                // for the next frame.
                CM_PENDING: if (copy && !commit) state_d = CM_IDLE;
                default:    state_d = CM_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) state_q <= CM_IDLE;
            else        state_q <= state_d;
        end

        assign commit_busy = (state_q == CM_PENDING);

        // A write during the copy clk goes into back only. Because of the
        // non-blocking update, the copy takes the pre-write back contents.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N_TILES; i++) back_q[i] <= '0;
            end else if (wr_ok) begin
                back_q[wr_addr] <= wr_data;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < N_TILES; i++) front_q[i] <= '0;
            end else if (copy) begin
                front_q <= back_q;
            end
        end
    end

    // ---------------- S1: tile read and flags; S2: output registers ---------
    logic [7:0] s1_rgb_q, rgb_q;
    logic       s1_act_q, s1_hs_q, s1_vs_q;
    logic       hsync_q, vsync_q, frame_start_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rgb_q      <= '0;
            s1_act_q      <= 1'b0;
            s1_hs_q       <= 1'b0;
            s1_vs_q       <= 1'b0;
            rgb_q         <= '0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
        end else begin
            frame_start_q <= pix_en && (h_q == '0) && (v_q == '0);
            if (pix_en) begin
                s1_rgb_q <= front_q[tile_idx];
                s1_act_q <= (h_q < HW'(H_ACTIVE)) && (v_q < VW'(V_ACTIVE));
                s1_hs_q  <= (h_q >= HW'(HS_START)) && (h_q < HW'(HS_END));
                s1_vs_q  <= (v_q >= VW'(VS_START)) && (v_q < VW'(VS_END));
                rgb_q    <= s1_act_q ? s1_rgb_q : 8'h00;
                hsync_q  <= s1_hs_q ? SYNC_POL : ~SYNC_POL;
                vsync_q  <= s1_vs_q ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    assign frame_start = frame_start_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = rgb_q[7:5];
    assign vga_g       = rgb_q[4:2];
    assign vga_b       = rgb_q[1:0];

endmodule
